// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source FIFOs for RS and LSB results, round-robin grant onto one registered broadcast bus.
// Optional broadcast/conflict statistics counters are enabled by defining CDB_STAT_EN.
module cdb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8,
  parameter int FIFO_WIDTH = 2,
  parameter int FIFO_DEPTH = 1 << FIFO_WIDTH
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  RoBCDB_pre_judge,
  input  logic                  RSCDB_en,
  input  logic [RoB_WIDTH-1:0]  RSCDB_RoB_index,
  input  logic [31:0]           RSCDB_value,
  input  logic [ADDR_WIDTH-1:0] RSCDB_next_pc,
  input  logic                  LSBCDB_en,
  input  logic [RoB_WIDTH-1:0]  LSBCDB_RoB_index,
  input  logic [31:0]           LSBCDB_value,
  output logic                  CDBRS_full,
  output logic                  CDBLSB_full,
  output logic                  CDB_en,
  output logic [RoB_WIDTH-1:0]  CDB_RoB_index,
  output logic [31:0]           CDB_value,
  output logic [ADDR_WIDTH-1:0] CDB_next_pc,
`ifdef CDB_STAT_EN
  output logic                  CDB_src,
  output logic [31:0]           CDB_stat_bcast,
  output logic [31:0]           CDB_stat_conflict
`else
  output logic                  CDB_src
`endif
);

  // Handshake: *CDB_en is a single-cycle valid with no ready; producers throttle on
  // *_full, which asserts one entry early so a registered producer cannot overflow.
  typedef enum logic {SRC_RS = 1'b0, SRC_LSB = 1'b1} src_e;

  localparam logic [FIFO_WIDTH:0]   CNT_DEPTH = (FIFO_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH:0]   CNT_FULL  = (FIFO_WIDTH+1)'(FIFO_DEPTH - 1);
  localparam logic [FIFO_WIDTH:0]   CNT_ZERO  = '0;
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE   = FIFO_WIDTH'(1);

  logic [RoB_WIDTH-1:0]  rs_idx_mem  [FIFO_DEPTH];
  logic [31:0]           rs_val_mem  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] rs_pc_mem   [FIFO_DEPTH];
  logic [RoB_WIDTH-1:0]  lsb_idx_mem [FIFO_DEPTH];
  logic [31:0]           lsb_val_mem [FIFO_DEPTH];

  logic [FIFO_WIDTH-1:0] rs_head, rs_tail, lsb_head, lsb_tail;
  logic [FIFO_WIDTH:0]   rs_cnt, lsb_cnt, rs_cnt_nxt, lsb_cnt_nxt;
  src_e                  last_grant;
  logic                  flush, advance;
  logic                  rs_ne, lsb_ne, grant_rs, grant_lsb, rs_push, lsb_push;

  // Grant is decided from pre-edge counts, so a push into an empty FIFO waits one edge.
  always_comb begin
    flush       = !RoBCDB_pre_judge;
    advance     = Sys_rdy && !flush;
    rs_ne       = (rs_cnt != CNT_ZERO);
    lsb_ne      = (lsb_cnt != CNT_ZERO);
    grant_rs    = rs_ne && (!lsb_ne || last_grant == SRC_LSB);
    grant_lsb   = lsb_ne && (!rs_ne || last_grant == SRC_RS);
    rs_push     = RSCDB_en && ((rs_cnt < CNT_DEPTH) || grant_rs);
    lsb_push    = LSBCDB_en && ((lsb_cnt < CNT_DEPTH) || grant_lsb);
    rs_cnt_nxt  = rs_cnt + (FIFO_WIDTH+1)'(rs_push) - (FIFO_WIDTH+1)'(grant_rs);
    lsb_cnt_nxt = lsb_cnt + (FIFO_WIDTH+1)'(lsb_push) - (FIFO_WIDTH+1)'(grant_lsb);
  end

  assign CDBRS_full  = (rs_cnt >= CNT_FULL);
  assign CDBLSB_full = (lsb_cnt >= CNT_FULL);

  always_ff @(posedge Sys_clk) begin
    if (advance && rs_push) begin
      rs_idx_mem[rs_tail] <= RSCDB_RoB_index;
      rs_val_mem[rs_tail] <= RSCDB_value;
      rs_pc_mem[rs_tail]  <= RSCDB_next_pc;
    end
    if (advance && lsb_push) begin
      lsb_idx_mem[lsb_tail] <= LSBCDB_RoB_index;
      lsb_val_mem[lsb_tail] <= LSBCDB_value;
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      rs_head       <= '0;
      rs_tail       <= '0;
      lsb_head      <= '0;
      lsb_tail      <= '0;
      rs_cnt        <= '0;
      lsb_cnt       <= '0;
      last_grant    <= SRC_LSB;
      CDB_en        <= 1'b0;
      CDB_src       <= 1'b0;
      CDB_RoB_index <= '0;
      CDB_value     <= '0;
      CDB_next_pc   <= '0;
    end else if (flush) begin
      rs_head    <= '0;
      rs_tail    <= '0;
      lsb_head   <= '0;
      lsb_tail   <= '0;
      rs_cnt     <= '0;
      lsb_cnt    <= '0;
      last_grant <= SRC_LSB;
      CDB_en     <= 1'b0;
    end else if (Sys_rdy) begin
      if (rs_push)  rs_tail  <= rs_tail + PTR_ONE;
      if (lsb_push) lsb_tail <= lsb_tail + PTR_ONE;
      rs_cnt  <= rs_cnt_nxt;
      lsb_cnt <= lsb_cnt_nxt;
      if (grant_rs) begin
        rs_head       <= rs_head + PTR_ONE;
        last_grant    <= SRC_RS;
        CDB_en        <= 1'b1;
        CDB_src       <= SRC_RS;
        CDB_RoB_index <= rs_idx_mem[rs_head];
        CDB_value     <= rs_val_mem[rs_head];
        CDB_next_pc   <= rs_pc_mem[rs_head];
      end else if (grant_lsb) begin
        lsb_head      <= lsb_head + PTR_ONE;
        last_grant    <= SRC_LSB;
        CDB_en        <= 1'b1;
        CDB_src       <= SRC_LSB;
        CDB_RoB_index <= lsb_idx_mem[lsb_head];
        CDB_value     <= lsb_val_mem[lsb_head];
        CDB_next_pc   <= '0;
      end else begin
        CDB_en <= 1'b0;
      end
    end
  end

`ifdef CDB_STAT_EN
  // Statistics survive a flush; only reset clears them.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      CDB_stat_bcast    <= '0;
      CDB_stat_conflict <= '0;
    end else if (advance) begin
      if (grant_rs || grant_lsb) CDB_stat_bcast <= CDB_stat_bcast + 32'd1;
      if (rs_ne && lsb_ne)       CDB_stat_conflict <= CDB_stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued as stimulus is issued and a monitor checks them in order.
// Statistics checks compile in when CDB_STAT_EN is defined.
module tb_cdb_arbiter;
  localparam int W = 73;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst = 1'b0;
  logic        Sys_rdy = 1'b1;
  logic        RoBCDB_pre_judge = 1'b1;
  logic        RSCDB_en = 1'b0;
  logic [7:0]  RSCDB_RoB_index = '0;
  logic [31:0] RSCDB_value = '0;
  logic [31:0] RSCDB_next_pc = '0;
  logic        LSBCDB_en = 1'b0;
  logic [7:0]  LSBCDB_RoB_index = '0;
  logic [31:0] LSBCDB_value = '0;
  logic        CDBRS_full, CDBLSB_full, CDB_en, CDB_src;
  logic [7:0]  CDB_RoB_index;
  logic [31:0] CDB_value, CDB_next_pc;
`ifdef CDB_STAT_EN
  logic [31:0] CDB_stat_bcast, CDB_stat_conflict;
`endif

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic edge_active = 1'b0;

  cdb_arbiter dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .RoBCDB_pre_judge(RoBCDB_pre_judge),
    .RSCDB_en(RSCDB_en), .RSCDB_RoB_index(RSCDB_RoB_index),
    .RSCDB_value(RSCDB_value), .RSCDB_next_pc(RSCDB_next_pc),
    .LSBCDB_en(LSBCDB_en), .LSBCDB_RoB_index(LSBCDB_RoB_index),
    .LSBCDB_value(LSBCDB_value),
    .CDBRS_full(CDBRS_full), .CDBLSB_full(CDBLSB_full),
    .CDB_en(CDB_en), .CDB_RoB_index(CDB_RoB_index), .CDB_value(CDB_value),
    .CDB_next_pc(CDB_next_pc),
`ifdef CDB_STAT_EN
    .CDB_src(CDB_src),
    .CDB_stat_bcast(CDB_stat_bcast),
    .CDB_stat_conflict(CDB_stat_conflict)
`else
    .CDB_src(CDB_src)
`endif
  );

  // Clock / reset-window bookkeeping
  always #5 Sys_clk = ~Sys_clk;

  always @(posedge Sys_clk)
    edge_active = !Sys_rst && RoBCDB_pre_judge && Sys_rdy;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rs_val(input logic [7:0] idx);
    return 32'hA000_0000 | {24'h0, idx};
  endfunction
  function automatic logic [31:0] rs_pc(input logic [7:0] idx);
    return 32'h0000_0400 + {22'h0, idx, 2'b00};
  endfunction
  function automatic logic [31:0] lsb_val(input logic [7:0] idx);
    return 32'hB000_0000 | {24'h0, idx};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic exp_rs(input logic [7:0] idx);
    exp_q.push_back({1'b0, idx, rs_val(idx), rs_pc(idx)});
  endtask
  task automatic exp_lsb(input logic [7:0] idx);
    exp_q.push_back({1'b1, idx, lsb_val(idx), 32'h0});
  endtask

  // Driver: present one cycle of inputs, then advance past the next rising edge.
  task automatic drive(input bit re, input logic [7:0] ri, input bit le, input logic [7:0] li);
    RSCDB_en         = re;
    RSCDB_RoB_index  = ri;
    RSCDB_value      = rs_val(ri);
    RSCDB_next_pc    = rs_pc(ri);
    LSBCDB_en        = le;
    LSBCDB_RoB_index = li;
    LSBCDB_value     = lsb_val(li);
    @(negedge Sys_clk);
  endtask

  task automatic idle(input int n);
    RSCDB_en  = 1'b0;
    LSBCDB_en = 1'b0;
    repeat (n) @(negedge Sys_clk);
  endtask

  // Monitor / scoreboard: each fresh broadcast must match the queue head.
  always @(negedge Sys_clk) begin
    if (edge_active && CDB_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL bcast_unexpected: got %h expected none",
                 {CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc});
      end else begin
        check("bcast", {CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc}, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state, visible before any clock edge
    #1 Sys_rst = 1'b1;
    #1;
    check("reset_cdb", {CDB_en, CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc}, '0);
    check("reset_full", {CDBRS_full, CDBLSB_full}, '0);
    @(negedge Sys_clk);
    @(negedge Sys_clk);
    Sys_rst = 1'b0;

    // Concurrent sources: RS wins the first tie, then strict alternation
    exp_rs(8'd1); exp_lsb(8'd2); exp_rs(8'd3); exp_lsb(8'd4); exp_rs(8'd5); exp_lsb(8'd6);
    drive(1, 8'd1, 1, 8'd2);
    drive(1, 8'd3, 1, 8'd4);
    drive(1, 8'd5, 1, 8'd6);
    idle(8);

    // Single RS result with explicit payload
    exp_q.push_back({1'b0, 8'd5, 32'h0000_1234, 32'h0000_0100});
    RSCDB_en = 1'b1; RSCDB_RoB_index = 8'd5; RSCDB_value = 32'h1234; RSCDB_next_pc = 32'h100;
    @(negedge Sys_clk);
    idle(1);
    check("single_en_hi", CDB_en, 1'b1);
    idle(1);
    check("single_en_lo", CDB_en, 1'b0);
    idle(2);

    // RS burst against a continuous LSB stream
    exp_lsb(8'h20); exp_rs(8'h10); exp_lsb(8'h21); exp_rs(8'h11); exp_lsb(8'h22);
    exp_rs(8'h12); exp_lsb(8'h23); exp_rs(8'h13); exp_lsb(8'h24); exp_lsb(8'h25);
    drive(1, 8'h10, 1, 8'h20);
    drive(1, 8'h11, 1, 8'h21);
    drive(1, 8'h12, 1, 8'h22);
    check("burst_rs_full_at2", CDBRS_full, 1'b0);
    drive(1, 8'h13, 1, 8'h23);
    check("burst_rs_full_at3", CDBRS_full, 1'b1);
    drive(0, 8'h00, 1, 8'h24);
    check("burst_lsb_full_at3", CDBLSB_full, 1'b1);
    drive(0, 8'h00, 1, 8'h25);
    idle(8);

    // Mispredict flush with three queued and a same-edge RS push
    exp_rs(8'h30);
    drive(1, 8'h30, 1, 8'h31);
    drive(1, 8'h32, 1, 8'h33);
    check("preflush_full", {CDBRS_full, CDBLSB_full}, '0);
    RoBCDB_pre_judge = 1'b0;
    drive(1, 8'h34, 0, 8'h00);
    RoBCDB_pre_judge = 1'b1;
    check("flush_en", CDB_en, 1'b0);
    check("flush_full", {CDBRS_full, CDBLSB_full}, '0);
    idle(6);
    check("flush_drained", W'(exp_q.size()), '0);
    exp_rs(8'h35);
    drive(1, 8'h35, 0, 8'h00);
    idle(3);

    // Stall with two entries queued and a live broadcast on the bus
    exp_lsb(8'h41); exp_rs(8'h40); exp_rs(8'h42);
    drive(1, 8'h40, 1, 8'h41);
    drive(1, 8'h42, 0, 8'h00);
    Sys_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("stall_cdb", {CDB_en, CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc},
            {1'b1, 1'b1, 8'h41, lsb_val(8'h41), 32'h0});
      check("stall_full", {CDBRS_full, CDBLSB_full}, '0);
`ifdef CDB_STAT_EN
      check("stall_stat_bcast", CDB_stat_bcast, 32'd20);
`endif
    end
    Sys_rdy = 1'b1;
    idle(4);

    // Asynchronous reset between edges, then first tie goes to RS
    exp_lsb(8'h51); exp_rs(8'h50);
    drive(1, 8'h50, 1, 8'h51);
    drive(1, 8'h52, 1, 8'h53);
    idle(1);
    #2 Sys_rst = 1'b1;
    #1;
    check("async_rst_cdb", {CDB_en, CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc}, '0);
    check("async_rst_full", {CDBRS_full, CDBLSB_full}, '0);
`ifdef CDB_STAT_EN
    check("async_rst_stat", {CDB_stat_bcast, CDB_stat_conflict}, '0);
`endif
    @(negedge Sys_clk);
    Sys_rst = 1'b0;
    exp_rs(8'h54); exp_lsb(8'h55);
    drive(1, 8'h54, 1, 8'h55);
    idle(5);

    // Final report
    check("all_expected_seen", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
